// File: rtl/fetch_prefetch_buffer_if.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_buffer_if
// Instruction-memory handshake between the fetch front-end and its memory.
//   req_valid  : fetch unit -> memory, request valid
//   req_ready  : memory -> fetch unit, request accepted this cycle
//   req_addr   : fetch unit -> memory, 4-byte aligned byte address
//   resp_valid : memory -> fetch unit, in-order response strobe
//   resp_data  : memory -> fetch unit, returned 32-bit instruction word
// Modports: master = fetch unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface fetch_prefetch_buffer_if;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;

   modport master (output req_valid, req_addr,
                   input  req_ready, resp_valid, resp_data);
   modport slave  (input  req_valid, req_addr,
                   output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_buffer
// Fetch front-end ahead of the IF/ID register. Owns the fetch PC, issues
// sequential requests to instruction memory, buffers the returned words in a
// DEPTH-entry FIFO and presents the head as PC_F / Instr_F / Valid_F.
// An Execute redirect flushes the FIFO and marks all in-flight requests as
// drops so their responses are discarded on return.
//
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   Stall_F         : hold the head, no pop
//   redirect_valid  : taken branch/jump in Execute
//   redirect_pc     : new fetch target (low two bits ignored)
//   mem             : instruction-memory handshake (master modport)
//   PC_F, Instr_F   : head PC and instruction (NOP_INSTR when empty)
//   Valid_F         : head holds a real instruction
//
// Optional build macro FETCH_PREFETCH_PERF_EN adds saturating counters
//   perf_empty_cycles, perf_redirects, perf_dropped.
// -----------------------------------------------------------------------------
module fetch_prefetch_buffer #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    Stall_F,
   input  logic                    redirect_valid,
   input  logic [63:0]             redirect_pc,
   fetch_prefetch_buffer_if.master mem,
   output logic [63:0]             PC_F,
   output logic [31:0]             Instr_F,
   output logic                    Valid_F
`ifdef FETCH_PREFETCH_PERF_EN
   ,
   output logic [31:0]             perf_empty_cycles,
   output logic [31:0]             perf_redirects,
   output logic [31:0]             perf_dropped
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   typedef logic [CW-1:0] cnt_t;
   typedef logic [PW-1:0] ptr_t;

   logic [63:0] fetch_pc_q, fetch_pc_d;
   logic [63:0] head_pc_q, head_pc_d;
   cnt_t        count_q, count_d;
   cnt_t        outstanding_q, outstanding_d;
   cnt_t        drop_cnt_q, drop_cnt_d;
   ptr_t        wr_ptr_q, wr_ptr_d;
   ptr_t        rd_ptr_q, rd_ptr_d;
   logic [31:0] buf_q [DEPTH];

   logic [CW:0] reserved;
   logic        resp_ok, accept, push, pop, drop;
   logic [63:0] target;
   logic        unused_pc_lsbs;

   assign unused_pc_lsbs = ^redirect_pc[1:0];
   assign target         = {redirect_pc[63:2], 2'b00};

   // FIFO slots already spoken for: held entries plus live (non-dropped)
   // in-flight requests. Reserving at issue time makes every push safe.
   assign reserved = {1'b0, count_q} + {1'b0, outstanding_q - drop_cnt_q};

   // rst gating keeps the request low while reset is held.
   assign mem.req_valid = !rst && !redirect_valid && (reserved < DEPTH_W);
   assign mem.req_addr  = fetch_pc_q;

   assign Valid_F = (count_q != '0);
   assign PC_F    = head_pc_q;
   assign Instr_F = Valid_F ? buf_q[rd_ptr_q] : NOP_INSTR;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign resp_ok = mem.resp_valid && (outstanding_q != '0);
   assign accept  = mem.req_valid && mem.req_ready;
   assign drop    = resp_ok && (redirect_valid || (drop_cnt_q != '0));
   assign push    = resp_ok && !redirect_valid && (drop_cnt_q == '0);
   assign pop     = Valid_F && !Stall_F && !redirect_valid;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      head_pc_d     = head_pc_q;
      count_d       = count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      drop_cnt_d    = drop_cnt_q;
      outstanding_d = outstanding_q + cnt_t'(accept) - cnt_t'(resp_ok);
      if (redirect_valid) begin
         // accept is 0 here, so everything still in flight becomes a drop.
         fetch_pc_d = target;
         head_pc_d  = target;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         drop_cnt_d = outstanding_q - cnt_t'(resp_ok);
      end else begin
         count_d = count_q + cnt_t'(push) - cnt_t'(pop);
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            head_pc_d = head_pc_q + 64'd4;
         end
         if (accept) fetch_pc_d = fetch_pc_q + 64'd4;
         if (resp_ok && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - cnt_t'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         head_pc_q     <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         head_pc_q     <= head_pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   // Storage needs no reset: Valid_F masks it while empty.
   always_ff @(posedge clk) begin
      if (push) buf_q[wr_ptr_q] <= mem.resp_data;
   end

`ifdef FETCH_PREFETCH_PERF_EN
   logic [31:0] perf_empty_q, perf_redir_q, perf_drop_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_empty_q <= '0;
         perf_redir_q <= '0;
         perf_drop_q  <= '0;
      end else begin
         if (!Valid_F && !Stall_F && (perf_empty_q != '1)) perf_empty_q <= perf_empty_q + 32'd1;
         if (redirect_valid && (perf_redir_q != '1))       perf_redir_q <= perf_redir_q + 32'd1;
         if (drop && (perf_drop_q != '1))                  perf_drop_q  <= perf_drop_q + 32'd1;
      end
   end

   assign perf_empty_cycles = perf_empty_q;
   assign perf_redirects    = perf_redir_q;
   assign perf_dropped      = perf_drop_q;
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif

   a_resp_without_req: assert property (@(posedge clk) disable iff (rst)
      !(mem.resp_valid && (outstanding_q == '0)));
   a_drop_le_outstanding: assert property (@(posedge clk) disable iff (rst)
      drop_cnt_q <= outstanding_q);

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
module tb_fetch_prefetch_buffer;
   localparam int          DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h0;
   localparam logic [31:0] NOP      = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Stall_F = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic [63:0] PC_F;
   logic [31:0] Instr_F;
   logic        Valid_F;
`ifdef FETCH_PREFETCH_PERF_EN
   logic [31:0] perf_empty_cycles, perf_redirects, perf_dropped;
`endif

   fetch_prefetch_buffer_if mif();

   fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .Stall_F(Stall_F),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem(mif), .PC_F(PC_F), .Instr_F(Instr_F), .Valid_F(Valid_F)
`ifdef FETCH_PREFETCH_PERF_EN
      , .perf_empty_cycles(perf_empty_cycles), .perf_redirects(perf_redirects),
      .perf_dropped(perf_dropped)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // ---------------- memory responder (stimulus) ----------------
   typedef struct { logic [63:0] addr; int due; } mreq_t;
   mreq_t mq[$];
   int    cyc = 0;
   int    mem_lat = 1;

   // ---------------- reference model ----------------
   // In-flight requests carry their address and whether a redirect made them
   // stale; the buffer holds (pc, word) pairs. PC of a buffered instruction
   // is simply the address it was fetched from.
   typedef struct { logic [63:0] addr; bit stale; } inf_t;
   typedef struct { logic [63:0] pc; logic [31:0] data; } ent_t;
   inf_t        m_inf[$];
   ent_t        m_fifo[$];
   logic [63:0] m_fetch, m_head;

   function automatic void model_reset();
      m_inf.delete();
      m_fifo.delete();
      m_fetch = RESET_PC;
      m_head  = RESET_PC;
   endfunction

   // Called at the falling edge: compare this cycle's outputs, then advance.
   task automatic check_and_step();
      int   fresh;
      logic exp_rv, acc, got;
      inf_t e;
      ent_t p;
      if (rst) model_reset();
      fresh = 0;
      foreach (m_inf[i]) if (!m_inf[i].stale) fresh++;
      exp_rv = !rst && !redirect_valid && ((m_fifo.size() + fresh) < DEPTH);
      chk("req_valid", mif.req_valid, exp_rv);
      chk("req_addr", mif.req_addr, m_fetch);
      chk("Valid_F", Valid_F, m_fifo.size() > 0);
      chk("PC_F", PC_F, (m_fifo.size() > 0) ? m_fifo[0].pc : m_head);
      chk("Instr_F", Instr_F, (m_fifo.size() > 0) ? m_fifo[0].data : NOP);
      if (rst) return;
      if (mif.req_valid && mif.req_ready) mq.push_back('{mif.req_addr, cyc + mem_lat});
      acc = exp_rv && mif.req_ready;
      got = 1'b0;
      e   = '{64'h0, 1'b0};
      if (mif.resp_valid && m_inf.size() > 0) begin
         e = m_inf.pop_front();
         got = 1'b1;
      end
      if (redirect_valid) begin
         foreach (m_inf[i]) m_inf[i].stale = 1'b1;
         m_fifo.delete();
         m_fetch = {redirect_pc[63:2], 2'b00};
         m_head  = m_fetch;
      end else begin
         if (m_fifo.size() > 0 && !Stall_F) begin
            p = m_fifo.pop_front();
            m_head = p.pc + 64'd4;
         end
         if (got && !e.stale) m_fifo.push_back('{e.addr, mif.resp_data});
         if (acc) begin
            m_inf.push_back('{m_fetch, 1'b0});
            m_fetch = m_fetch + 64'd4;
         end
      end
   endtask

   task automatic tick(input logic st, input logic rd, input logic [63:0] rpc, input logic rdy);
      @(posedge clk);
      #1;
      cyc++;
      rst            = 1'b0;
      Stall_F        = st;
      redirect_valid = rd;
      redirect_pc    = rpc;
      mif.req_ready  = rdy;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         mif.resp_valid = 1'b1;
         mif.resp_data  = mq[0].addr[31:0];
         void'(mq.pop_front());
      end else begin
         mif.resp_valid = 1'b0;
         mif.resp_data  = '0;
      end
      @(negedge clk);
      check_and_step();
   endtask

   // Asserts reset right now (between edges) and checks outputs at once.
   task automatic hold_reset(input int n);
      rst = 1'b1;
      model_reset();
      mq.delete();
      mif.resp_valid = 1'b0;
      mif.req_ready  = 1'b0;
      Stall_F        = 1'b0;
      redirect_valid = 1'b0;
      #1;
      chk("rst_PC_F", PC_F, RESET_PC);
      chk("rst_Valid_F", Valid_F, 1'b0);
      chk("rst_req_valid", mif.req_valid, 1'b0);
      chk("rst_Instr_F", Instr_F, NOP);
      chk("rst_req_addr", mif.req_addr, RESET_PC);
      repeat (n) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         check_and_step();
      end
   endtask

   task automatic wait_valid(input string nm, input logic [63:0] exp_pc);
      int n = 0;
      while (!Valid_F && n < 40) begin
         tick(1'b1, 1'b0, 64'h0, 1'b1);
         n++;
      end
      vectors++;
      if (!Valid_F) begin
         miscompares++;
         $display("FAIL %s_timeout: Valid_F still 0 after %0d cycles, required 1", nm, n);
      end else begin
         chk({nm, "_pc"}, PC_F, exp_pc);
         chk({nm, "_instr"}, Instr_F, exp_pc[31:0]);
      end
   endtask

   initial begin
      logic [63:0] pc0;
      mif.req_ready  = 1'b0;
      mif.resp_valid = 1'b0;
      mif.resp_data  = '0;
      @(negedge clk);
      hold_reset(2);

      // 1: streaming with one-cycle memory
      mem_lat = 1;
      tick(1'b0, 1'b0, 64'h0, 1'b1);
      chk("t1_c0_rv", mif.req_valid, 1'b1);
      chk("t1_c0_addr", mif.req_addr, 64'h0);
      tick(1'b0, 1'b0, 64'h0, 1'b1);
      chk("t1_c1_addr", mif.req_addr, 64'h4);
      chk("t1_c1_vf", Valid_F, 1'b0);
      tick(1'b0, 1'b0, 64'h0, 1'b1);
      chk("t1_c2_addr", mif.req_addr, 64'h8);
      chk("t1_c2_vf", Valid_F, 1'b1);
      chk("t1_c2_pc", PC_F, 64'h0);
      chk("t1_c2_instr", Instr_F, 64'h0);
      tick(1'b0, 1'b0, 64'h0, 1'b1);
      chk("t1_c3_addr", mif.req_addr, 64'hC);
      chk("t1_c3_pc", PC_F, 64'h4);
      repeat (6) tick(1'b0, 1'b0, 64'h0, 1'b1);

      // 2: stall fills the buffer, then drains in order
      repeat (10) tick(1'b1, 1'b0, 64'h0, 1'b1);
      pc0 = PC_F;
      chk("t2_pc_frozen", PC_F, 64'h20);
      chk("t2_req_low", mif.req_valid, 1'b0);
      chk("t2_count", 64'(dut.count_q), 64'd4);
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 1'b0, 64'h0, 1'b1);
         chk("t2_pop_pc", PC_F, pc0 + 64'(4 * i));
         chk("t2_pop_vf", Valid_F, 1'b1);
      end

      // 3: redirect with three slow requests in flight
      hold_reset(2);
      mem_lat = 6;
      repeat (3) tick(1'b0, 1'b0, 64'h0, 1'b1);
      tick(1'b0, 1'b1, 64'h1000, 1'b1);
      chk("t3_redir_rv", mif.req_valid, 1'b0);
      tick(1'b0, 1'b0, 64'h0, 1'b1);
      chk("t3_vf", Valid_F, 1'b0);
      chk("t3_drop", 64'(dut.drop_cnt_q), 64'd3);
      chk("t3_addr", mif.req_addr, 64'h1000);
      chk("t3_rv", mif.req_valid, 1'b1);
      wait_valid("t3_first", 64'h1000);
      repeat (4) tick(1'b0, 1'b0, 64'h0, 1'b1);

      // 4: redirect coinciding with a response and a stall
      hold_reset(2);
      mem_lat = 2;
      repeat (4) tick(1'b1, 1'b0, 64'h0, 1'b1);
      chk("t4_vf_before", Valid_F, 1'b1);
      tick(1'b1, 1'b1, 64'h2002, 1'b1);
      chk("t4_resp_in_redir", mif.resp_valid, 1'b1);
      tick(1'b1, 1'b0, 64'h0, 1'b1);
      chk("t4_vf", Valid_F, 1'b0);
      chk("t4_drop", 64'(dut.drop_cnt_q), 64'd1);
      chk("t4_addr", mif.req_addr, 64'h2000);
      wait_valid("t4_first", 64'h2000);
      repeat (4) tick(1'b0, 1'b0, 64'h0, 1'b1);

      // 5: memory back-pressure holds the address; buffer drains to NOP
      hold_reset(2);
      mem_lat = 1;
      repeat (8) tick(1'b0, 1'b0, 64'h0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 1'b0, 64'h0, 1'b0);
         chk("t5_addr", mif.req_addr, 64'h20);
         chk("t5_rv", mif.req_valid, 1'b1);
      end
      chk("t5_nop", Instr_F, 64'h13);
      chk("t5_vf", Valid_F, 1'b0);
      repeat (4) tick(1'b0, 1'b0, 64'h0, 1'b1);

      // 6: asynchronous reset mid-stream
      repeat (3) tick(1'b0, 1'b0, 64'h0, 1'b1);
      #2;
      hold_reset(2);
      tick(1'b0, 1'b0, 64'h0, 1'b1);
      chk("t6_addr", mif.req_addr, RESET_PC);
      chk("t6_rv", mif.req_valid, 1'b1);
      wait_valid("t6_first", RESET_PC);

      // 7: fetch PC wraps through 2^64
      tick(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
      tick(1'b0, 1'b0, 64'h0, 1'b1);
      chk("t7_addr0", mif.req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
      tick(1'b0, 1'b0, 64'h0, 1'b1);
      chk("t7_addr1", mif.req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      tick(1'b0, 1'b0, 64'h0, 1'b1);
      chk("t7_addr2", mif.req_addr, 64'h0);
      wait_valid("t7_first", 64'hFFFF_FFFF_FFFF_FFF8);
      repeat (8) tick(1'b0, 1'b0, 64'h0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
